ternary_mac_array: RTL and testbench
====================================

# ternary_mac_array

Multi-lane, parametrised ternary multiply-accumulate engine for the MatMul-free datapath. One signed activation stream is broadcast to `LANES` parallel accumulators, and each lane has its own 2-bit ternary weight per beat. After a programmed vector length the block requantises each lane (arithmetic shift, optional ReLU, saturating clamp) and presents all lanes as one packed output word. Input and output use ready/valid handshakes. It sits between the activation buffer and the next-layer activation FIFO.

## Interface
- `ACT_W`, 8: activation width, signed two's complement.
- `LANES`, 4: number of parallel output neurons.
- `ACC_W`, 20: accumulator width, signed; must be ≥ `ACT_W`+1.
- `OUT_W`, 8: per-lane output width, signed.
- `LEN_W`, 8: vector-length field width.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `ena`  in  1: global enable; low freezes all state.
- `start`  in  1: begin a new vector; sampled only in IDLE or on an OUTPUT handshake cycle.
- `abort`  in  1: synchronous discard; returns to IDLE from any state.
- `cfg_len`  in  `LEN_W`: number of elements minus 1; latched on `start`.
- `cfg_shift`  in  4: arithmetic right shift applied before the clamp; latched on `start`.
- `cfg_relu`  in  1: clamp negative results to 0; latched on `start`.
- `in_valid`  in  1: input beat valid.
- `in_ready`  out  1: high in ACCUM when `ena`=1.
- `act`  in  `ACT_W`: signed activation, shared by all lanes.
- `wts`  in  2·`LANES`: weight for lane i is `wts[2i+1:2i]`. Encoding: 01 = +1, 10 = −1, 00/11 = 0.
- `out_valid`  out  1: result valid; held until accepted.
- `out_ready`  in  1: downstream accept.
- `out_data`  out  `LANES`·`OUT_W`: lane i is `out_data[OUT_W·i +: OUT_W]`.
- `ovf`  out  `LANES`: sticky per-lane accumulator-saturation flag for the current vector.
- `busy`  out  1: state ≠ IDLE.

## Operation
- **FSM states:** IDLE, ACCUM, QUANT, OUTPUT.
- **IDLE:**
  - On `start`: latch the config, zero the accumulators, the beat counter and `ovf`, then go to ACCUM.
- **ACCUM:**
  - A beat is accepted when `in_valid & in_ready`.
  - On each beat, every lane adds +`act`, −`act` or 0, with `act` sign-extended to `ACC_W`.
  - Each add saturates at ±`ACC_W` bounds (−2^(ACC_W−1) to 2^(ACC_W−1)−1). Any clamp sets that lane's `ovf` bit.
  - The counter increments on each beat. When the beat occurs with counter == `cfg_len`, go to QUANT.
- **QUANT** (exactly one cycle): for each lane, compute s = acc >>> `cfg_shift`.
  - If `cfg_relu` and s < 0, then s = 0.
  - Clamp s to [−2^(OUT_W−1), 2^(OUT_W−1)−1] and register the result into `out_data`.
  - Go to OUTPUT.
- **OUTPUT:**
  - `out_valid`=1; `out_data` and `ovf` are held stable.
  - On `out_ready`, go to IDLE. If `start` is also high in that cycle, go directly to ACCUM with the new config (back-to-back vectors).
- **abort:** overrides every other input and returns to IDLE next edge. It clears `out_valid` and the counter; `out_data` and `ovf` keep their last values.
- **ena=0:** no state, counter, accumulator or output changes. `in_ready`=0; `out_valid` is held. `start` and `abort` are ignored.
- `start` in ACCUM or QUANT is ignored.
- `cfg_len`=0 means a 1-element vector. `cfg_len`=2^LEN_W−1 means the maximum-length vector. The counter never wraps within a vector.

## Timing
- **Reset values:** state IDLE; `in_ready`, `out_valid`, `busy`, `ovf` and `out_data` all 0; accumulators 0.
- **Reset mid-operation:** immediate return to these values, with no partial output.
- **Start:** `start` at edge t makes `in_ready` high after edge t; the first beat can be accepted at edge t+1.
- **Throughput:** one beat per cycle when `in_valid` is held high.
- **Latency:** the last beat accepted at edge k gives QUANT during cycle k→k+1 and `out_valid` high after edge k+1. Worst-case `out_data` path is a single register stage.
- **Minimum vector period:** N+2 cycles (N beats + QUANT + one OUTPUT cycle with `out_ready`=1).
- **Output:** `out_data` changes only on the QUANT→OUTPUT edge. `ovf` changes only in ACCUM or on `start`.

## Test plan
- **Basic dot product.** Config `cfg_len`=3, shift 0, relu 0. Acts 10, 20, −5, 7. Lane weights: lane0 all +1; lane1 all −1; lane2 all 00/11; lane3 +1, −1, +1, −1. Expect lanes {32, −32, 0, −22}, `ovf`=0, and `out_valid` 2 cycles after the last beat.
- **Clamp and shift.** Config `cfg_len`=255, act=127 every beat, lane0 +1, lane1 −1.
  - With shift 0: expect lane0=127, lane1=−128.
  - With shift 8: expect lane0=127, lane1=−127.
- **Accumulator saturation** (`ACC_W`=12). 20 beats of act=127 at +1: expect the accumulator to saturate at 2047, `ovf[0]`=1, and output 127. `ovf` is cleared by the next `start`.
- **ReLU.** Repeat the basic scenario with `cfg_relu`=1: expect {32, 0, 0, 0}.
- **Backpressure and gaps.**
  - Random `in_valid` gaps give the same result as the basic scenario.
  - Holding `out_ready`=0 for 5 cycles keeps `out_valid` and `out_data` stable.
  - `start` asserted together with `out_ready` begins the next vector with no IDLE cycle.
- **Abort, reset and ena.**
  - `abort` after 2 beats: IDLE, `out_valid` never asserted.
  - `rst_n` low mid-ACCUM: all outputs 0 immediately.
  - `ena`=0 for 3 cycles mid-vector: result unchanged versus the uninterrupted run.

Source files
------------

// File: rtl/ternary_mac_array.sv
// Multi-lane ternary multiply-accumulate engine: one broadcast activation stream,
// per-lane {+1,-1,0} weights, saturating accumulators and a shift/ReLU/clamp requantiser.
module ternary_mac_array #(
  parameter int ACT_W = 8,
  parameter int LANES = 4,
  parameter int ACC_W = 20,
  parameter int OUT_W = 8,
  parameter int LEN_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     start,
  input  logic                     abort,
  input  logic [LEN_W-1:0]         cfg_len,
  input  logic [3:0]               cfg_shift,
  input  logic                     cfg_relu,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ACT_W-1:0]         act,
  input  logic [2*LANES-1:0]       wts,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*OUT_W-1:0]   out_data,
  output logic [LANES-1:0]         ovf,
  output logic                     busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_QUANT, S_OUTPUT} state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q;
  logic [3:0]       shift_q;
  logic             relu_q;

  logic load_cfg;
  logic beat;
  logic last_beat;
  logic do_quant;

  // Shared qualifiers; abort and ena=0 suppress every state-changing event.
  always_comb begin
    load_cfg  = ena & ~abort & start &
                ((state_q == S_IDLE) | ((state_q == S_OUTPUT) & out_ready));
    beat      = ena & ~abort & (state_q == S_ACCUM) & in_valid;
    last_beat = beat & (cnt_q == len_q);
    do_quant  = ena & ~abort & (state_q == S_QUANT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ena) begin
      if (abort) begin
        state_d = S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE:   if (start) state_d = S_ACCUM;
          S_ACCUM:  if (last_beat) state_d = S_QUANT;
          S_QUANT:  state_d = S_OUTPUT;
          S_OUTPUT: if (out_ready) state_d = start ? S_ACCUM : S_IDLE;
          default:  state_d = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    in_ready  = ena & (state_q == S_ACCUM);
    out_valid = (state_q == S_OUTPUT);
    busy      = (state_q != S_IDLE);
  end

  // The counter parks at len on the final beat so it never wraps at the maximum length.
  always_comb begin
    cnt_d = cnt_q;
    if (ena & abort) begin
      cnt_d = '0;
    end else if (load_cfg) begin
      cnt_d = '0;
    end else if (beat & ~last_beat) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      len_q   <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (load_cfg) begin
        len_q   <= cfg_len;
        shift_q <= cfg_shift;
        relu_q  <= cfg_relu;
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    ovf_q;
    logic [OUT_W-1:0]        out_q;
    logic [1:0]              w;
    logic signed [ACC_W:0]   act_ext, term, sum;
    logic                    sat;
    logic signed [ACC_W-1:0] shifted, relued;
    logic [OUT_W-1:0]        quant;

    // One guard bit above the accumulator detects overflow of the add.
    always_comb begin
      w       = wts[2*gi +: 2];
      act_ext = (ACC_W+1)'($signed(act));
      unique case (w)
        2'b01:   term = act_ext;
        2'b10:   term = -act_ext;
        default: term = '0;
      endcase
      sum = $signed({acc_q[ACC_W-1], acc_q}) + term;
      sat = sum[ACC_W] ^ sum[ACC_W-1];
      if (!sat) begin
        acc_d = sum[ACC_W-1:0];
      end else if (sum[ACC_W]) begin
        acc_d = ACC_MIN;
      end else begin
        acc_d = ACC_MAX;
      end

      shifted = acc_q >>> shift_q;
      relued  = (relu_q && shifted[ACC_W-1]) ? '0 : shifted;
      if (relued > OUT_MAX) begin
        quant = OUT_MAX[OUT_W-1:0];
      end else if (relued < OUT_MIN) begin
        quant = OUT_MIN[OUT_W-1:0];
      end else begin
        quant = relued[OUT_W-1:0];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
        out_q <= '0;
      end else begin
        if (load_cfg) begin
          acc_q <= '0;
          ovf_q <= 1'b0;
        end else if (beat) begin
          acc_q <= acc_d;
          if (sat) ovf_q <= 1'b1;
        end
        if (do_quant) out_q <= quant;
      end
    end

    assign out_data[gi*OUT_W +: OUT_W] = out_q;
    assign ovf[gi]                     = ovf_q;
  end

endmodule

// File: tb/tb_ternary_mac_array.sv
// Directed, table-driven bench for ternary_mac_array; a 12-bit-accumulator
// instance shares the stimulus for the saturation vectors.
module tb_ternary_mac_array;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] cfg_len = '0;
  logic [3:0] cfg_shift = '0;
  logic       cfg_relu = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] act = '0;
  logic [7:0] wts = '0;
  logic       out_ready = 1'b0;

  logic        a_in_ready, a_out_valid, a_busy;
  logic [31:0] a_out_data;
  logic [3:0]  a_ovf;
  logic        b_in_ready, b_out_valid, b_busy;
  logic [31:0] b_out_data;
  logic [3:0]  b_ovf;

  logic        sel12 = 1'b0;
  logic [31:0] cur_data;
  logic [3:0]  cur_ovf;
  assign cur_data = sel12 ? b_out_data : a_out_data;
  assign cur_ovf  = sel12 ? b_ovf : a_ovf;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ternary_mac_array #(.ACT_W(8), .LANES(4), .ACC_W(20), .OUT_W(8), .LEN_W(8)) dut20 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .abort(abort),
    .cfg_len(cfg_len), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .in_valid(in_valid), .in_ready(a_in_ready), .act(act), .wts(wts),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .ovf(a_ovf), .busy(a_busy)
  );

  ternary_mac_array #(.ACT_W(8), .LANES(4), .ACC_W(12), .OUT_W(8), .LEN_W(8)) dut12 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .abort(abort),
    .cfg_len(cfg_len), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .in_valid(in_valid), .in_ready(b_in_ready), .act(act), .wts(wts),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .ovf(b_ovf), .busy(b_busy)
  );

  typedef struct {
    int          len;
    int          shift;
    bit          relu;
    bit          rep;
    bit          use12;
    logic [31:0] act;
    logic [31:0] w;
    logic [31:0] exp;
    logic [3:0]  exp_ovf;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic begin_vec(input int idx);
    @(negedge clk);
    sel12     = tbl[idx].use12;
    start     = 1'b1;
    cfg_len   = tbl[idx].len[7:0];
    cfg_shift = tbl[idx].shift[3:0];
    cfg_relu  = tbl[idx].relu;
    @(posedge clk);
  endtask

  task automatic send_beat(input int idx, input int b);
    int k;
    k = tbl[idx].rep ? 0 : b;
    @(negedge clk);
    start    = 1'b0;
    abort    = 1'b0;
    ena      = 1'b1;
    in_valid = 1'b1;
    act      = tbl[idx].act[8*k +: 8];
    wts      = tbl[idx].w[8*k +: 8];
    #1;
    if (b == 0) chk($sformatf("v%0d_in_ready", idx), {31'b0, a_in_ready}, 32'd1);
    @(posedge clk);
  endtask

  task automatic finish_vec(input int idx, input int hold, input int nxt);
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    chk($sformatf("v%0d_quant_no_valid", idx), {31'b0, a_out_valid}, 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_out_valid", idx), {31'b0, a_out_valid}, 32'd1);
    chk($sformatf("v%0d_out_data", idx), cur_data, tbl[idx].exp);
    chk($sformatf("v%0d_ovf", idx), {28'b0, cur_ovf}, {28'b0, tbl[idx].exp_ovf});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk($sformatf("v%0d_hold_valid", idx), {31'b0, a_out_valid}, 32'd1);
      chk($sformatf("v%0d_hold_data", idx), cur_data, tbl[idx].exp);
    end
    out_ready = 1'b1;
    if (nxt >= 0) begin
      start     = 1'b1;
      cfg_len   = tbl[nxt].len[7:0];
      cfg_shift = tbl[nxt].shift[3:0];
      cfg_relu  = tbl[nxt].relu;
    end
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    #1;
    if (nxt >= 0) chk($sformatf("v%0d_b2b_in_ready", idx), {31'b0, a_in_ready}, 32'd1);
    else          chk($sformatf("v%0d_idle", idx), {31'b0, a_busy}, 32'd0);
  endtask

  task automatic run_vec(input int idx, input bit gaps);
    begin_vec(idx);
    for (int b = 0; b <= tbl[idx].len; b++) begin
      if (gaps && (b == 1 || $urandom_range(0, 1) == 1)) begin
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
      end
      send_beat(idx, b);
    end
    finish_vec(idx, 0, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    // wts byte = {lane3, lane2, lane1, lane0}; 8'h49 = +1,0,-1,+1 (lane3..0), 8'hB9 = -1,0(11),-1,+1
    tbl[0] = '{len: 3, shift: 0, relu: 1'b0, rep: 1'b0, use12: 1'b0,
               act: pk(10, 20, -5, 7), w: pk('h49, 'hB9, 'h49, 'hB9),
               exp: pk(32, -32, 0, -22), exp_ovf: 4'b0000};
    tbl[1] = '{len: 3, shift: 0, relu: 1'b1, rep: 1'b0, use12: 1'b0,
               act: pk(10, 20, -5, 7), w: pk('h49, 'hB9, 'h49, 'hB9),
               exp: pk(32, 0, 0, 0), exp_ovf: 4'b0000};
    tbl[2] = '{len: 255, shift: 0, relu: 1'b0, rep: 1'b1, use12: 1'b0,
               act: pk(127, 0, 0, 0), w: pk('h09, 0, 0, 0),
               exp: pk(127, -128, 0, 0), exp_ovf: 4'b0000};
    tbl[3] = '{len: 255, shift: 8, relu: 1'b0, rep: 1'b1, use12: 1'b0,
               act: pk(127, 0, 0, 0), w: pk('h09, 0, 0, 0),
               exp: pk(127, -127, 0, 0), exp_ovf: 4'b0000};
    tbl[4] = '{len: 3, shift: 2, relu: 1'b0, rep: 1'b0, use12: 1'b0,
               act: pk(10, 20, -5, 7), w: pk('h49, 'hB9, 'h49, 'hB9),
               exp: pk(8, -8, 0, -6), exp_ovf: 4'b0000};
    tbl[5] = '{len: 0, shift: 0, relu: 1'b0, rep: 1'b0, use12: 1'b0,
               act: pk(-128, 0, 0, 0), w: pk('h39, 0, 0, 0),
               exp: pk(-128, 127, 0, 0), exp_ovf: 4'b0000};
    tbl[6] = '{len: 19, shift: 5, relu: 1'b0, rep: 1'b1, use12: 1'b1,
               act: pk(127, 0, 0, 0), w: pk('h09, 0, 0, 0),
               exp: pk(63, -64, 0, 0), exp_ovf: 4'b0011};
    tbl[7] = '{len: 3, shift: 0, relu: 1'b0, rep: 1'b0, use12: 1'b1,
               act: pk(10, 20, -5, 7), w: pk('h49, 'hB9, 'h49, 'hB9),
               exp: pk(32, -32, 0, -22), exp_ovf: 4'b0000};
    tbl[8] = tbl[6];

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, a_in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, a_out_valid}, 32'd0);
    chk("rst_busy", {31'b0, a_busy}, 32'd0);
    chk("rst_ovf", {28'b0, a_ovf}, 32'd0);
    chk("rst_out_data", a_out_data, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i, 1'b0);

    // Reset mid-ACCUM on top of a saturated dut12 result
    begin_vec(0);
    send_beat(0, 0);
    send_beat(0, 1);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_data12", b_out_data, 32'd0);
    chk("midrst_ovf12", {28'b0, b_ovf}, 32'd0);
    chk("midrst_data20", a_out_data, 32'd0);
    chk("midrst_busy", {31'b0, a_busy}, 32'd0);
    chk("midrst_in_ready", {31'b0, a_in_ready}, 32'd0);
    chk("midrst_out_valid", {31'b0, a_out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random input gaps
    run_vec(0, 1'b1);

    // Output backpressure, then back-to-back start with the ReLU config
    begin_vec(0);
    for (int b = 0; b < 4; b++) send_beat(0, b);
    finish_vec(0, 5, 1);
    for (int b = 0; b < 4; b++) send_beat(1, b);
    finish_vec(1, 0, -1);

    // Abort after two beats
    begin_vec(0);
    send_beat(0, 0);
    send_beat(0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    abort    = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {31'b0, a_busy}, 32'd0);
    chk("abort_keep_data", a_out_data, tbl[1].exp);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_valid", {31'b0, a_out_valid}, 32'd0);
    end
    run_vec(0, 1'b0);

    // ena low for three cycles mid-vector, with start/abort/beat noise that must be ignored
    begin_vec(0);
    send_beat(0, 0);
    send_beat(0, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ena      = 1'b0;
      in_valid = 1'b1;
      act      = 8'h37;
      wts      = 8'h55;
      abort    = 1'b1;
      start    = 1'b1;
      #1;
      chk("ena_in_ready", {31'b0, a_in_ready}, 32'd0);
      chk("ena_busy", {31'b0, a_busy}, 32'd1);
    end
    send_beat(0, 2);
    send_beat(0, 3);
    finish_vec(0, 0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
